alu_writeback: RTL

- Result stage directly downstream of the 16-bit ALU in the FSM CPU.
- Captures the 32-bit ALU result plus the five compare flags (za, zb, eq, gt, lt).
- Writes the result into the 16-bit register file: one write cycle for narrow ops, two cycles (low half, then high half) for wide ops such as the multiply product.
- Maintains the architectural status register read by the control FSM for branches.

---
 rtl/cpu_pkg.sv | 23 ++
 rtl/alu_writeback.sv | 125 ++++++++++++
 2 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, writeback FSM states and
// status-register bit positions.
package cpu_pkg;

  localparam int DATA_W = 16;
  localparam int RES_W  = 32;
  localparam int ADDR_W = 3;
  localparam int ST_W   = 6;

  typedef enum logic [1:0] {
    WB_IDLE = 2'd0,
    WB_LO   = 2'd1,
    WB_HI   = 2'd2
  } wb_state_t;

  localparam int ST_ZA = 0;
  localparam int ST_ZB = 1;
  localparam int ST_EQ = 2;
  localparam int ST_GT = 3;
  localparam int ST_LT = 4;
  localparam int ST_OV = 5;

endpackage

// File: rtl/alu_writeback.sv
// ALU result stage: writes 32-bit results into the 16-bit register file in
// one or two cycles and keeps the status register. ALUWB_WRCOUNT_EN adds wr_count.
module alu_writeback
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [RES_W-1:0]  result,
  input  logic              za,
  input  logic              zb,
  input  logic              eq,
  input  logic              gt,
  input  logic              lt,
  input  logic [ADDR_W-1:0] dest_addr,
  input  logic              wide,
  input  logic              flag_en,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [ST_W-1:0]   status,
  output logic              busy,
  output logic              done,
`ifdef ALUWB_WRCOUNT_EN
  output logic [15:0]       wr_count,
`endif
  output logic [1:0]        state_dbg
);

  // Handshake: an op transfers on a rising edge where in_valid && in_ready.
  // in_valid is a don't-care while in_ready=0 (nothing is queued), and
  // in_ready is forced low while rst_n is asserted.

  wb_state_t         state_q, state_d;
  logic [RES_W-1:0]  res_q;
  logic [ADDR_W-1:0] dest_q;
  logic              wide_q;
  logic [ST_W-1:0]   status_q, status_d;
  logic              ready_st;
  logic              accept;

  always_comb begin
    state_d  = WB_IDLE;
    ready_st = 1'b0;
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      WB_IDLE: ready_st = 1'b1;
      WB_LO: begin
        rf_we    = 1'b1;
        rf_waddr = dest_q;
        rf_wdata = res_q[DATA_W-1:0];
        busy     = 1'b1;
        if (!wide_q) begin
          done     = 1'b1;
          ready_st = 1'b1;
        end
      end
      WB_HI: begin
        rf_we    = 1'b1;
        rf_waddr = dest_q + ADDR_W'(1);
        rf_wdata = res_q[RES_W-1:DATA_W];
        busy     = 1'b1;
        done     = 1'b1;
        ready_st = 1'b1;
      end
      default: ;
    endcase
    in_ready = rst_n & ready_st;
    accept   = in_valid & in_ready;
    if (state_q == WB_LO && wide_q) state_d = WB_HI;
    else if (accept)                state_d = WB_LO;
  end

  // ov flags a narrow write that dropped nonzero high bits.
  always_comb begin
    status_d        = '0;
    status_d[ST_ZA] = za;
    status_d[ST_ZB] = zb;
    status_d[ST_EQ] = eq;
    status_d[ST_GT] = gt;
    status_d[ST_LT] = lt;
    status_d[ST_OV] = !wide && (result[RES_W-1:DATA_W] != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= WB_IDLE;
      res_q    <= '0;
      dest_q   <= '0;
      wide_q   <= 1'b0;
      status_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        res_q  <= result;
        dest_q <= dest_addr;
        wide_q <= wide;
        if (flag_en) status_q <= status_d;
      end
    end
  end

  assign status    = status_q;
  assign state_dbg = state_q;

`ifdef ALUWB_WRCOUNT_EN
  logic [15:0] wr_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_count_q <= '0;
    end else if (rf_we && wr_count_q != 16'hFFFF) begin
      wr_count_q <= wr_count_q + 16'd1;
    end
  end

  assign wr_count = wr_count_q;
`endif

endmodule
